// File: rtl/uart_tx_frame_seq.sv
// Frame sequencer for the UART byte transmitter: latches a BYTE_NUM-byte word on a start
// request and feeds it byte by byte, paced by the byte transmitter's done pulse.
module uart_tx_frame_seq #(
  parameter int unsigned BYTE_NUM   = 5,
  parameter bit          LSB_FIRST  = 1'b1,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [8*BYTE_NUM-1:0] i_data_in,
  input  logic                  i_trans_go,
  input  logic                  i_byte_tx_done,
  output logic [7:0]            o_byte_data,
  output logic                  o_byte_send_go,
  output logic                  o_busy,
  output logic                  o_trans_done
);

  localparam int unsigned CNT_W = (BYTE_NUM > 1) ? $clog2(BYTE_NUM) : 1;
  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BYTE_NUM - 1);
  localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    StIdle,
    StSend,
    StWait,
    StGap,
    StDone
  } state_e;

  state_e                r_state;
  state_e                w_state_d;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_d;
  logic [GAP_W-1:0]      r_gap;
  logic [GAP_W-1:0]      w_gap_d;
  logic [8*BYTE_NUM-1:0] r_frame;
  logic [8*BYTE_NUM-1:0] w_frame_d;
  logic [CNT_W-1:0]      w_idx;
  logic [7:0]            w_byte_sel;
  logic [7:0]            r_byte_data;
  logic                  r_send_go;
  logic                  r_busy;
  logic                  r_trans_done;

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_gap_d   = r_gap;
    w_frame_d = r_frame;
    unique case (r_state)
      StIdle: begin
        if (i_trans_go) begin
          w_frame_d = i_data_in;
          w_cnt_d   = '0;
          w_state_d = StSend;
        end
      end
      StSend: w_state_d = StWait;
      StWait: begin
        if (i_byte_tx_done) begin
          if (r_cnt == LAST_CNT) begin
            w_state_d = StDone;
          end else begin
            w_cnt_d   = r_cnt + 1'b1;
            w_gap_d   = '0;
            w_state_d = (GAP_CYCLES > 0) ? StGap : StSend;
          end
        end
      end
      StGap: begin
        if (r_gap == LAST_GAP) begin
          w_state_d = StSend;
        end else begin
          w_gap_d = r_gap + 1'b1;
        end
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Byte chosen from the next-state frame/count so it lands together with send_go.
  always_comb begin
    w_idx      = LSB_FIRST ? w_cnt_d : (LAST_CNT - w_cnt_d);
    w_byte_sel = '0;
    for (int unsigned k = 0; k < BYTE_NUM; k++) begin
      if (w_idx == CNT_W'(k)) begin
        w_byte_sel = w_frame_d[8*k +: 8];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_gap        <= '0;
      r_frame      <= '0;
      r_byte_data  <= '0;
      r_send_go    <= 1'b0;
      r_busy       <= 1'b0;
      r_trans_done <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_cnt        <= w_cnt_d;
      r_gap        <= w_gap_d;
      r_frame      <= w_frame_d;
      r_send_go    <= (w_state_d == StSend);
      r_busy       <= (w_state_d != StIdle);
      r_trans_done <= (w_state_d == StDone);
      if (w_state_d == StSend) begin
        r_byte_data <= w_byte_sel;
      end
    end
  end

  assign o_byte_data    = r_byte_data;
  assign o_byte_send_go = r_send_go;
  assign o_busy         = r_busy;
  assign o_trans_done   = r_trans_done;

endmodule

// File: tb/tb_uart_tx_frame_seq.sv
// Bench for uart_tx_frame_seq: three instances (defaults, MSB-first, 3-cycle gap) share the
// stimulus; a schedule-based model is checked every cycle, plus literal frame expectations.
module tb_uart_tx_frame_seq;

  localparam int NB       = 5;
  localparam int W        = 8 * NB;
  localparam int ND       = 3;
  localparam int RESP_LAT = 20;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] data_in = '0;
  logic         trans_go = 1'b0;
  logic         spur_done = 1'b0;
  logic         resp_done [ND] = '{1'b0, 1'b0, 1'b0};
  logic         tx_done   [ND];
  logic [7:0]   byte_data [ND];
  logic         send_go   [ND];
  logic         busy      [ND];
  logic         trans_done[ND];

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int i = 0; i < ND; i++) tx_done[i] = resp_done[i] | spur_done;
  end

  uart_tx_frame_seq #(.BYTE_NUM(NB), .LSB_FIRST(1'b1), .GAP_CYCLES(0)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_data_in(data_in), .i_trans_go(trans_go),
    .i_byte_tx_done(tx_done[0]), .o_byte_data(byte_data[0]), .o_byte_send_go(send_go[0]),
    .o_busy(busy[0]), .o_trans_done(trans_done[0])
  );
  uart_tx_frame_seq #(.BYTE_NUM(NB), .LSB_FIRST(1'b0), .GAP_CYCLES(0)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_data_in(data_in), .i_trans_go(trans_go),
    .i_byte_tx_done(tx_done[1]), .o_byte_data(byte_data[1]), .o_byte_send_go(send_go[1]),
    .o_busy(busy[1]), .o_trans_done(trans_done[1])
  );
  uart_tx_frame_seq #(.BYTE_NUM(NB), .LSB_FIRST(1'b1), .GAP_CYCLES(3)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_data_in(data_in), .i_trans_go(trans_go),
    .i_byte_tx_done(tx_done[2]), .o_byte_data(byte_data[2]), .o_byte_send_go(send_go[2]),
    .o_busy(busy[2]), .o_trans_done(trans_done[2])
  );

  function automatic bit lsb_of(input int i);
    return (i != 1);
  endfunction

  function automatic int gap_of(input int i);
    return (i == 2) ? 3 : 0;
  endfunction

  function automatic logic [7:0] pick(input logic [W-1:0] f, input int k, input bit lsb);
    int idx;
    idx = lsb ? k : NB - 1 - k;
    return f[8*idx +: 8];
  endfunction

  // Model: schedules the cycle numbers of send_go / trans_done from the timing rules.
  int           m_send_at[ND];
  int           m_done_at[ND];
  int           m_k      [ND];
  bit           m_busy   [ND];
  bit           m_wait   [ND];
  logic [W-1:0] m_frame  [ND];
  logic [7:0]   e_data   [ND];
  logic         e_send   [ND];
  logic         e_done   [ND];
  logic         e_busy   [ND];

  always @(posedge clk or posedge rst) begin
    int c;
    c = cyc;
    for (int i = 0; i < ND; i++) begin
      if (rst) begin
        m_busy[i] = 0; m_wait[i] = 0; m_k[i] = 0;
        m_send_at[i] = -10; m_done_at[i] = -10; m_frame[i] = '0;
        e_data[i] = 8'h00; e_send[i] = 0; e_done[i] = 0; e_busy[i] = 0;
      end else begin
        if (!m_busy[i] && trans_go) begin
          m_busy[i] = 1; m_frame[i] = data_in; m_k[i] = 0; m_wait[i] = 0;
          m_send_at[i] = c + 1; m_done_at[i] = -10;
        end else if (m_wait[i] && tx_done[i]) begin
          m_wait[i] = 0;
          if (m_k[i] == NB - 1) m_done_at[i] = c + 1;
          else begin
            m_k[i]++;
            m_send_at[i] = c + 1 + gap_of(i);
          end
        end
        if (c == m_send_at[i]) m_wait[i] = 1;
        if (c == m_done_at[i]) m_busy[i] = 0;
        e_send[i] = (m_send_at[i] == c + 1);
        e_done[i] = (m_done_at[i] == c + 1);
        e_busy[i] = m_busy[i];
        if (e_send[i]) e_data[i] = pick(m_frame[i], m_k[i], lsb_of(i));
      end
    end
  end

  // Byte-transmitter stand-in plus a log of what each instance emitted.
  int         last_send[ND];
  int         last_tx  [ND];
  int         nlog     [ND];
  int         ndone    [ND];
  logic [7:0] blog     [ND][64];
  int         scyc     [ND][64];
  int         sprev    [ND][64];
  int         dprev    [ND][64];

  always @(negedge clk) begin
    for (int i = 0; i < ND; i++) begin
      if (rst) begin
        last_send[i] = -1000;
        last_tx[i]   = -1000;
      end else begin
        if (tx_done[i]) last_tx[i] = cyc;
        if (send_go[i]) begin
          last_send[i]           = cyc;
          blog[i][nlog[i] % 64]  = byte_data[i];
          scyc[i][nlog[i] % 64]  = cyc;
          sprev[i][nlog[i] % 64] = last_tx[i];
          nlog[i]++;
        end
        if (trans_done[i]) begin
          dprev[i][ndone[i] % 64] = cyc - last_tx[i];
          ndone[i]++;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < ND; i++) resp_done[i] = (cyc == last_send[i] + RESP_LAT);
  end

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < ND; i++) begin
      chk($sformatf("dut%0d_send_go", i), 40'(send_go[i]), 40'(e_send[i]));
      chk($sformatf("dut%0d_trans_done", i), 40'(trans_done[i]), 40'(e_done[i]));
      chk($sformatf("dut%0d_busy", i), 40'(busy[i]), 40'(e_busy[i]));
      chk($sformatf("dut%0d_byte_data", i), 40'(byte_data[i]), 40'(e_data[i]));
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_go(input logic [W-1:0] d);
    data_in  = d;
    trans_go = 1'b1;
    tick();
    trans_go = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    int n;
    n = 0;
    tick();
    while ((busy[0] | busy[1] | busy[2]) && n < lim) begin
      tick();
      n++;
    end
    if (n >= lim) begin
      n_checks++; n_errs++;
      $display("FAIL idle_timeout: still busy after %0d cycles, required idle", lim);
    end
  endtask

  int b[ND];
  int d[ND];

  task automatic snap();
    for (int i = 0; i < ND; i++) begin
      b[i] = nlog[i];
      d[i] = ndone[i];
    end
  endtask

  // Bytes given in LSB-first order; the MSB-first instance must emit them reversed.
  task automatic check_frame(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3, input logic [7:0] e4);
    logic [7:0] e[5];
    e = '{e0, e1, e2, e3, e4};
    for (int i = 0; i < ND; i++) begin
      chk($sformatf("%s_dut%0d_nbytes", tag, i), 40'(nlog[i] - b[i]), 40'd5);
      chk($sformatf("%s_dut%0d_ndone", tag, i), 40'(ndone[i] - d[i]), 40'd1);
      for (int k = 0; k < 5; k++) begin
        chk($sformatf("%s_dut%0d_byte%0d", tag, i, k), 40'(blog[i][(b[i] + k) % 64]),
            40'((i == 1) ? e[4-k] : e[k]));
      end
    end
  endtask

  initial begin
    int n;
    int go_cyc;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < ND; i++) begin
      chk($sformatf("reset_dut%0d_outputs", i),
          40'({byte_data[i], send_go[i], busy[i], trans_done[i]}), 40'd0);
    end
    rst = 1'b0;
    tick();

    // Basic frame on all three instances.
    snap();
    go_cyc = cyc;
    pulse_go(40'h1122334455);
    wait_idle(600);
    check_frame("basic", 8'h55, 8'h44, 8'h33, 8'h22, 8'h11);
    for (int i = 0; i < ND; i++) begin
      chk($sformatf("basic_dut%0d_first_send", i), 40'(scyc[i][b[i] % 64]), 40'(go_cyc + 1));
      chk($sformatf("basic_dut%0d_done_lat", i), 40'(dprev[i][d[i] % 64]), 40'd1);
      chk($sformatf("basic_dut%0d_busy_after", i), 40'(busy[i]), 40'd0);
    end
    for (int k = 1; k < 5; k++) begin
      chk($sformatf("gap0_byte%0d", k),
          40'(scyc[0][(b[0] + k) % 64] - sprev[0][(b[0] + k) % 64]), 40'd1);
      chk($sformatf("gap3_byte%0d", k),
          40'(scyc[2][(b[2] + k) % 64] - sprev[2][(b[2] + k) % 64]), 40'd4);
    end

    // trans_go mid-frame and in the trans_done cycle, with data_in changed.
    snap();
    pulse_go(40'hA1B2C3D4E5);
    n = 0;
    while (nlog[0] - b[0] < 2 && n < 300) begin tick(); n++; end
    pulse_go(40'h0F0F0F0F0F);
    n = 0;
    while (!trans_done[0] && n < 300) begin tick(); n++; end
    chk("ignore_go_reached_done", 40'(trans_done[0]), 40'd1);
    pulse_go(40'hFFEEDDCCBB);
    wait_idle(600);
    repeat (5) tick();
    check_frame("ignore_go", 8'hE5, 8'hD4, 8'hC3, 8'hB2, 8'hA1);

    // Spurious byte_tx_done in idle and coincident with byte_send_go.
    snap();
    spur_done = 1'b1;
    tick();
    spur_done = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < ND; i++) begin
      chk($sformatf("spur_idle_dut%0d", i), 40'({busy[i], 8'(nlog[i] - b[i])}), 40'd0);
    end
    data_in  = 40'h0102030405;
    trans_go = 1'b1;
    tick();
    trans_go  = 1'b0;
    spur_done = 1'b1;
    tick();
    spur_done = 1'b0;
    wait_idle(600);
    check_frame("spur", 8'h05, 8'h04, 8'h03, 8'h02, 8'h01);
    chk("spur_second_send", 40'(scyc[0][(b[0] + 1) % 64] - scyc[0][b[0] % 64]), 40'd21);

    // Reset mid-frame, then a fresh frame.
    snap();
    pulse_go(40'h5A6B7C8D9E);
    n = 0;
    while (nlog[0] - b[0] < 2 && n < 300) begin tick(); n++; end
    repeat (10) tick();
    rst = 1'b1;
    #1;
    for (int i = 0; i < ND; i++) begin
      chk($sformatf("midreset_dut%0d_outputs", i),
          40'({byte_data[i], send_go[i], busy[i], trans_done[i]}), 40'd0);
    end
    repeat (2) tick();
    rst = 1'b0;
    snap();
    repeat (30) tick();
    for (int i = 0; i < ND; i++) begin
      chk($sformatf("midreset_dut%0d_no_done", i), 40'(ndone[i] - d[i]), 40'd0);
    end
    snap();
    pulse_go(40'hC0FFEE1234);
    wait_idle(600);
    check_frame("restart", 8'h34, 8'h12, 8'hEE, 8'hFF, 8'hC0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
